// File: rtl/cpu_bus_responder.sv
// CPU bus responder: sequences each request as a T1..T4 M-cycle, serves HRAM and IE
// internally and forwards other addresses to an external port with wait states.
module cpu_bus_responder #(
  parameter int unsigned MAX_WAIT  = 15,
  parameter logic [15:0] HRAM_BASE = 16'hFF80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cpu_bus_op,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        mcycle_start,
  output logic [7:0]  cpu_din,
  output logic        cpu_din_valid,
  output logic [7:0]  ir,
  output logic        ir_cb,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  ie_reg,
  output logic        bus_timeout
);

  localparam int unsigned WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned HRAM_SIZE = 127;

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_IF    = 3'd1,
    OP_WRITE = 3'd2,
    OP_READ  = 3'd3,
    OP_IF_CB = 3'd4
  } bus_opcode_t;

  typedef enum logic [1:0] {T1, T2, T3, T4} tstate_t;

  tstate_t           state_q;
  bus_opcode_t       op_q;
  logic [15:0]       addr_q;
  logic [7:0]        dout_q;
  logic [WAIT_W-1:0] wait_q;
  logic              mcyc_q;
  logic [7:0]        cpu_din_q;
  logic              valid_q;
  logic [7:0]        ir_q;
  logic              ir_cb_q;
  logic [15:0]       mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [7:0]        mem_wdata_q;
  logic [7:0]        ie_q;
  logic              timeout_q;
  logic [7:0]        hram_q [0:HRAM_SIZE-1];

  bus_opcode_t op_in_c;
  logic        in_ext_c;
  logic        hit_hram_c;
  logic        hit_ie_c;
  logic        rd_op_c;
  logic        wr_op_c;
  logic        ext_act_c;
  logic [6:0]  hram_idx_c;
  logic        done_c;
  logic        tmo_c;
  logic [7:0]  data_c;
  logic        hram_we_c;

  // Request decode and T3 completion logic
  always_comb begin
    op_in_c    = (cpu_bus_op > 3'd4) ? OP_IDLE : bus_opcode_t'(cpu_bus_op);
    in_ext_c   = (cpu_addr < HRAM_BASE);
    hit_ie_c   = (addr_q == 16'hFFFF);
    hit_hram_c = (addr_q >= HRAM_BASE) && !hit_ie_c;
    rd_op_c    = (op_q == OP_IF) || (op_q == OP_READ) || (op_q == OP_IF_CB);
    wr_op_c    = (op_q == OP_WRITE);
    ext_act_c  = (addr_q < HRAM_BASE) && (rd_op_c || wr_op_c);
    hram_idx_c = 7'(addr_q - HRAM_BASE);
    done_c     = 1'b0;
    tmo_c      = 1'b0;
    data_c     = hit_ie_c ? ie_q : hram_q[hram_idx_c];
    if (state_q == T3) begin
      if (!ext_act_c) begin
        done_c = 1'b1;
      end else if (mem_ready) begin
        done_c = 1'b1;
        data_c = mem_rdata;
      end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
        done_c = 1'b1;
        tmo_c  = 1'b1;
        data_c = 8'hFF;
      end
    end
    hram_we_c = !reset && done_c && hit_hram_c && wr_op_c;
  end

  // HRAM storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (hram_we_c) hram_q[hram_idx_c] <= dout_q;
  end

  // T-state sequencer with registered bus and CPU-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= T1;
      op_q        <= OP_IDLE;
      addr_q      <= 16'h0000;
      dout_q      <= 8'h00;
      wait_q      <= '0;
      mcyc_q      <= 1'b1;
      cpu_din_q   <= 8'h00;
      valid_q     <= 1'b0;
      ir_q        <= 8'h00;
      ir_cb_q     <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      ie_q        <= 8'h00;
      timeout_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        T1: begin
          op_q    <= op_in_c;
          addr_q  <= cpu_addr;
          dout_q  <= cpu_dout;
          wait_q  <= '0;
          mcyc_q  <= 1'b0;
          state_q <= T2;
          if (in_ext_c && (op_in_c != OP_IDLE)) begin
            mem_addr_q <= cpu_addr;
            mem_rd_q   <= (op_in_c != OP_WRITE);
            mem_wr_q   <= (op_in_c == OP_WRITE);
            if (op_in_c == OP_WRITE) mem_wdata_q <= cpu_dout;
          end
        end
        T2: state_q <= T3;
        T3: begin
          if (done_c) begin
            state_q   <= T4;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            timeout_q <= tmo_c;
            if (rd_op_c) begin
              cpu_din_q <= data_c;
              valid_q   <= 1'b1;
            end
            if (op_q == OP_IF || op_q == OP_IF_CB) begin
              ir_q    <= data_c;
              ir_cb_q <= (op_q == OP_IF_CB);
            end
            if (hit_ie_c && wr_op_c) ie_q <= dout_q;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        T4: begin
          state_q <= T1;
          mcyc_q  <= 1'b1;
        end
      endcase
    end
  end

  assign mcycle_start  = mcyc_q;
  assign cpu_din       = cpu_din_q;
  assign cpu_din_valid = valid_q;
  assign ir            = ir_q;
  assign ir_cb         = ir_cb_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_wdata     = mem_wdata_q;
  assign ie_reg        = ie_q;
  assign bus_timeout   = timeout_q;

endmodule
